// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM for the multicycle RV32I core
//
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives every datapath select and enable. Outputs are Moore-style:
// decoded from the state register plus the (stable) IR fields.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   opcode, func3, func7     instruction fields from the IR (func7[5] only)
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite
//   ResultSrc, ALUSrc1, ALUSrc2, ALUControl, ImmSrc
//   branch, sel_branch       conditional PC load and condition select
//   illegal_instr            one-cycle pulse in DECODE for unsupported encodings
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrc1,
    output logic [1:0] ALUSrc2,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       branch,
    output logic [1:0] sel_branch,
    output logic       illegal_instr
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_PC,
        S_JAL_WB,
        S_LUI
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       w_alu_f3_ok;
    logic [2:0] w_alu_op;
    logic       w_br_f3_ok;
    logic [1:0] w_br_sel;
    logic       w_legal;

    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_branch;
    logic       w_illegal;

    // Only func7[5] distinguishes add/sub; the other bits are don't-care.
    logic       w_unused_func7;
    assign w_unused_func7 = &{1'b0, func7[6], func7[4:0]};

    // ALU function from func3; the sub variant applies to R-type only.
    always_comb begin
        w_alu_f3_ok = 1'b1;
        w_alu_op    = ALU_ADD;
        case (func3)
            3'b000:  w_alu_op = (opcode == OP_R && func7[5]) ? ALU_SUB : ALU_ADD;
            3'b111:  w_alu_op = ALU_AND;
            3'b110:  w_alu_op = ALU_OR;
            3'b010:  w_alu_op = ALU_SLT;
            3'b100:  w_alu_op = ALU_XOR;
            default: w_alu_f3_ok = 1'b0;
        endcase
    end

    // Branch condition select: func3 bits {2,0} once the encoding is legal.
    assign w_br_f3_ok = (func3 == 3'b000) || (func3 == 3'b001) ||
                        (func3 == 3'b100) || (func3 == 3'b101);
    assign w_br_sel   = {func3[2], func3[0]};

    always_comb begin
        case (opcode)
            OP_R, OP_I:                            w_legal = w_alu_f3_ok;
            OP_B:                                  w_legal = w_br_f3_ok;
            OP_LW, OP_SW, OP_JAL, OP_JALR, OP_LUI: w_legal = 1'b1;
            default:                               w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'd0;
        ALUSrc1     = 2'd0;
        ALUSrc2     = 2'd0;
        ALUControl  = ALU_ADD;
        ImmSrc      = IMM_I;
        sel_branch  = 2'd0;

        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                ALUSrc2    = 2'd2;
                ResultSrc  = 2'd2;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut captures OldPC+imm as a speculative branch/jal target.
                ALUSrc1 = 2'd1;
                ALUSrc2 = 2'd1;
                ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                if (!w_legal) begin
                    w_illegal = 1'b1;
                    w_next    = S_FETCH;
                end else begin
                    case (opcode)
                        OP_R:    w_next = S_EXEC_R;
                        OP_I:    w_next = S_EXEC_I;
                        OP_LW:   w_next = S_MEM_ADDR;
                        OP_SW:   w_next = S_MEM_ADDR;
                        OP_B:    w_next = S_BRANCH;
                        OP_JAL:  w_next = S_JAL;
                        OP_JALR: w_next = S_JALR;
                        default: w_next = S_LUI;
                    endcase
                end
            end
            S_EXEC_R: begin
                ALUSrc1    = 2'd2;
                ALUControl = w_alu_op;
                w_next     = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALUSrc1    = 2'd2;
                ALUSrc2    = 2'd1;
                ALUControl = w_alu_op;
                w_next     = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrc1 = 2'd2;
                ALUSrc2 = 2'd1;
                ImmSrc  = (opcode == OP_SW) ? IMM_S : IMM_I;
                w_next  = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                AdrSrc = 1'b1;
                w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                ResultSrc   = 2'd1;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_WRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrc1    = 2'd2;
                ALUControl = ALU_SUB;
                w_branch   = 1'b1;
                sel_branch = w_br_sel;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target in ALUOut while the ALU forms OldPC+4.
                w_pc_write = 1'b1;
                ALUSrc1    = 2'd1;
                ALUSrc2    = 2'd2;
                w_next     = S_JAL_WB;
            end
            S_JALR: begin
                ALUSrc1 = 2'd2;
                ALUSrc2 = 2'd1;
                w_next  = S_JALR_PC;
            end
            S_JALR_PC: begin
                w_pc_write = 1'b1;
                ALUSrc1    = 2'd1;
                ALUSrc2    = 2'd2;
                w_next     = S_JAL_WB;
            end
            S_JAL_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_LUI: begin
                ImmSrc      = IMM_U;
                ResultSrc   = 2'd3;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // While reset is low the state already reads FETCH, so selects show FETCH
    // values; only the enables need to be masked off.
    assign PCWrite       = w_pc_write  & rst;
    assign MemWrite      = w_mem_write & rst;
    assign IRWrite       = w_ir_write  & rst;
    assign RegWrite      = w_reg_write & rst;
    assign branch        = w_branch    & rst;
    assign illegal_instr = w_illegal   & rst;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrc1, ALUSrc2;
    logic [2:0] ALUControl, ImmSrc;
    logic       branch;
    logic [1:0] sel_branch;
    logic       illegal_instr;

    int total = 0;
    int bad   = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .branch(branch),
        .sel_branch(sel_branch), .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [20:0] dut_v;
    assign dut_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrc1,
                    ALUSrc2, ALUControl, ImmSrc, branch, sel_branch, illegal_instr};

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011, B = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111;

    function automatic logic [20:0] mk(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, a1, a2,
                                       input logic [2:0] alu, imm,
                                       input logic br, input logic [1:0] sel,
                                       input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a1, a2, alu, imm, br, sel, ill};
    endfunction

    function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            R, I:                  return f3 inside {3'd0, 3'd7, 3'd6, 3'd2, 3'd4};
            B:                     return f3 inside {3'd0, 3'd1, 3'd4, 3'd5};
            LW, SW, JAL, JALR, LUI: return 1'b1;
            default:               return 1'b0;
        endcase
    endfunction

    function automatic int ncycles(input logic [6:0] op, input logic [2:0] f3);
        if (!legal(op, f3)) return 2;
        case (op)
            B, LUI:       return 3;
            LW, JALR:     return 5;
            default:      return 4;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic [6:0] f7,
                                          input bit is_r);
        case (f3)
            3'd0:    return (is_r && f7[5]) ? 3'd1 : 3'd0;
            3'd7:    return 3'd2;
            3'd6:    return 3'd3;
            3'd2:    return 3'd4;
            default: return 3'd5;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = FETCH) of one instruction.
    function automatic logic [20:0] model(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7, input int k);
        logic [1:0] sel;
        sel = (f3 == 3'd0) ? 2'd0 : (f3 == 3'd1) ? 2'd1 : (f3 == 3'd4) ? 2'd2 : 2'd3;
        if (k == 0) return mk(1,0,0,1,0, 2,0,2, 0,0, 0,0,0);
        if (k == 1) return mk(0,0,0,0,0, 0,1,1, 0,(op == JAL) ? 3'd3 : 3'd2, 0,0,
                              !legal(op, f3));
        case (op)
            R:  return (k == 2) ? mk(0,0,0,0,0, 0,2,0, alu_of(f3,f7,1),0, 0,0,0)
                                : mk(0,0,0,0,1, 0,0,0, 0,0, 0,0,0);
            I:  return (k == 2) ? mk(0,0,0,0,0, 0,2,1, alu_of(f3,f7,0),0, 0,0,0)
                                : mk(0,0,0,0,1, 0,0,0, 0,0, 0,0,0);
            LW: return (k == 2) ? mk(0,0,0,0,0, 0,2,1, 0,0, 0,0,0)
                     : (k == 3) ? mk(0,1,0,0,0, 0,0,0, 0,0, 0,0,0)
                                : mk(0,0,0,0,1, 1,0,0, 0,0, 0,0,0);
            SW: return (k == 2) ? mk(0,0,0,0,0, 0,2,1, 0,1, 0,0,0)
                                : mk(0,1,1,0,0, 0,0,0, 0,0, 0,0,0);
            B:  return mk(0,0,0,0,0, 0,2,0, 1,0, 1,sel,0);
            JAL: return (k == 2) ? mk(1,0,0,0,0, 0,1,2, 0,0, 0,0,0)
                                 : mk(0,0,0,0,1, 0,0,0, 0,0, 0,0,0);
            JALR: return (k == 2) ? mk(0,0,0,0,0, 0,2,1, 0,0, 0,0,0)
                       : (k == 3) ? mk(1,0,0,0,0, 0,1,2, 0,0, 0,0,0)
                                  : mk(0,0,0,0,1, 0,0,0, 0,0, 0,0,0);
            default: return mk(0,0,0,0,1, 3,0,0, 0,4, 0,0,0);
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [20:0] got,
                       input logic [20:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, k, got, exp);
        end
    endtask

    // Enter at a negedge while the DUT is in FETCH; leaves at the negedge
    // of the following FETCH.
    task automatic run_instr(input string name, input logic [6:0] op,
                             input logic [2:0] f3, input logic [6:0] f7, input int n);
        opcode = op; func3 = f3; func7 = f7;
        for (int k = 0; k < n; k++) begin
            #1;
            chk(name, k, dut_v, model(op, f3, f7, k));
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        int         cycles;
        logic       ill;
        logic [2:0] alu;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl[16];
    logic [20:0] rst_v;
    logic [6:0]  ops[8];

    initial begin
        tbl[0]  = '{"add",   R,    3'd0, 7'h00, 4, 0, 3'd0, 2'd0};
        tbl[1]  = '{"sub",   R,    3'd0, 7'h20, 4, 0, 3'd1, 2'd0};
        tbl[2]  = '{"and",   R,    3'd7, 7'h00, 4, 0, 3'd2, 2'd0};
        tbl[3]  = '{"slti",  I,    3'd2, 7'h20, 4, 0, 3'd4, 2'd0};
        tbl[4]  = '{"lw",    LW,   3'd2, 7'h00, 5, 0, 3'd0, 2'd0};
        tbl[5]  = '{"sw",    SW,   3'd2, 7'h00, 4, 0, 3'd0, 2'd0};
        tbl[6]  = '{"beq",   B,    3'd0, 7'h00, 3, 0, 3'd1, 2'd0};
        tbl[7]  = '{"bne",   B,    3'd1, 7'h00, 3, 0, 3'd1, 2'd1};
        tbl[8]  = '{"blt",   B,    3'd4, 7'h00, 3, 0, 3'd1, 2'd2};
        tbl[9]  = '{"bge",   B,    3'd5, 7'h00, 3, 0, 3'd1, 2'd3};
        tbl[10] = '{"jal",   JAL,  3'd0, 7'h00, 4, 0, 3'd0, 2'd0};
        tbl[11] = '{"jalr",  JALR, 3'd0, 7'h00, 5, 0, 3'd0, 2'd0};
        tbl[12] = '{"lui",   LUI,  3'd0, 7'h00, 3, 0, 3'd0, 2'd0};
        tbl[13] = '{"ill7f", 7'h7f, 3'd0, 7'h00, 2, 1, 3'd0, 2'd0};
        tbl[14] = '{"illR1", R,    3'd1, 7'h00, 2, 1, 3'd0, 2'd0};
        tbl[15] = '{"illB2", B,    3'd2, 7'h00, 2, 1, 3'd0, 2'd0};
        ops = '{R, I, LW, SW, B, JAL, JALR, LUI};
        rst_v = mk(0,0,0,0,0, 2,0,2, 0,0, 0,0,0);

        rst = 1'b0; opcode = 7'd0; func3 = 3'd0; func7 = 7'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 0, dut_v, rst_v);
        rst = 1'b1;

        // Table: full per-cycle sequence plus the table's own key outputs.
        foreach (tbl[i]) begin
            opcode = tbl[i].op; func3 = tbl[i].f3; func7 = tbl[i].f7;
            #1;
            chk({tbl[i].name, "_fetch"}, 0, dut_v, model(tbl[i].op, tbl[i].f3, tbl[i].f7, 0));
            @(posedge clk); @(negedge clk); #1;
            chk({tbl[i].name, "_ill"}, 1, {20'd0, illegal_instr}, {20'd0, tbl[i].ill});
            @(posedge clk); @(negedge clk); #1;
            if (tbl[i].cycles > 2) begin
                if (tbl[i].op == R || tbl[i].op == I || tbl[i].op == B)
                    chk({tbl[i].name, "_alu"}, 2, {18'd0, ALUControl}, {18'd0, tbl[i].alu});
                if (tbl[i].op == B)
                    chk({tbl[i].name, "_sel"}, 2, {19'd0, sel_branch}, {19'd0, tbl[i].sel});
                repeat (tbl[i].cycles - 2) begin @(posedge clk); @(negedge clk); end
            end
            run_instr(tbl[i].name, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].cycles);
        end

        // Mid-MEM_WRITE reset drops MemWrite at once; release gives FETCH enables.
        opcode = SW; func3 = 3'd2; func7 = 7'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("sw_pre_rst", k, dut_v, model(SW, 3'd2, 7'd0, k));
            if (k < 3) begin @(posedge clk); @(negedge clk); end
        end
        #1 rst = 1'b0;
        #1 chk("rst_async", 0, dut_v, rst_v);
        @(posedge clk); @(negedge clk);
        chk("rst_hold", 0, dut_v, rst_v);
        rst = 1'b1;
        run_instr("post_rst_jalr", JALR, 3'd0, 7'd0, 5);

        // Randomized instructions against the reference model.
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic [6:0] f7;
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 7'($urandom);
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            run_instr("rand", op, f3, f7, ncycles(op, f3));
        end
        #1 chk("final_fetch", 0, dut_v, model(R, 3'd0, 7'd0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core. It sits directly upstream of the datapath and drives every select and enable the datapath consumes. It decodes `opcode`/`func3`/`func7` returned from the instruction register and sequences each instruction through fetch, decode, execute, memory and writeback cycles. Outputs are Moore-style, decoded from the current state plus the instruction fields.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset; state forced to FETCH while low
- `opcode`  in  7  instr[6:0]
- `func3`  in  3  instr[14:12]
- `func7`  in  7  instr[31:25]; only bit 5 is used
- `PCWrite`  out  1  unconditional PC load from Result
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result
- `MemWrite`  out  1  data memory write strobe
- `IRWrite`  out  1  load IR and OldPC
- `RegWrite`  out  1  register file write
- `ResultSrc`  out  2  0 = ALUOut, 1 = MDR, 2 = ALUResult, 3 = ImmExt
- `ALUSrc1`  out  2  0 = PC, 1 = OldPC, 2 = A
- `ALUSrc2`  out  2  0 = B, 1 = ImmExt, 2 = constant 4
- `ALUControl`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 XOR
- `ImmSrc`  out  3  0 = I, 1 = S, 2 = B, 3 = J, 4 = U
- `branch`  out  1  conditional PC load, qualified in the datapath by the condition select
- `sel_branch`  out  2  0 = beq, 1 = bne, 2 = blt, 3 = bge; carries func3 {2,0} mapped
- `illegal_instr`  out  1  one-cycle pulse in DECODE when the opcode or func is unsupported

## Operation
- **Supported opcodes:**
  - R 0110011: add, sub, and, or, slt, xor
  - I 0010011: addi, andi, ori, slti, xori
  - lw 0000011, sw 0100011
  - B 1100011: beq, bne, blt, bge
  - jal 1101111, jalr 1100111, lui 0110111
- **Enable defaults:** all enables are 0 unless listed. Unlisted mux selects are 0, ImmSrc is I, and ALUControl is ADD.
- **FETCH:** AdrSrc=0, IRWrite=1, ALUSrc1=0, ALUSrc2=2, ResultSrc=2, PCWrite=1. Next state: DECODE.
- **DECODE:** ALUSrc1=1, ALUSrc2=1, ADD.
  - ImmSrc is J for jal and B otherwise, so ALUOut captures OldPC+imm.
  - Next state by opcode: EXEC_R, EXEC_I, MEM_ADDR, BRANCH, JAL, JALR, or LUI.
  - Unsupported opcode or func: illegal_instr=1, next state FETCH, no architectural write.
- **EXEC_R:** ALUSrc1=2, ALUSrc2=0.
  - ALUControl from func3: 000 gives ADD, or SUB when func7[5]=1. 111 AND, 110 OR, 010 SLT, 100 XOR.
  - Next state: ALU_WB.
- **EXEC_I:** ALUSrc1=2, ALUSrc2=1, ImmSrc=I, same func3 map with func7 ignored. Next state: ALU_WB.
- **ALU_WB:** ResultSrc=0, RegWrite=1. Next state: FETCH.
- **MEM_ADDR:** ALUSrc1=2, ALUSrc2=1, ADD; ImmSrc is I for lw and S for sw. Next state: MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ:** AdrSrc=1, ResultSrc=0. Next state: MEM_WB.
- **MEM_WB:** ResultSrc=1, RegWrite=1. Next state: FETCH.
- **MEM_WRITE:** AdrSrc=1, ResultSrc=0, MemWrite=1. Next state: FETCH.
- **BRANCH:** ALUSrc1=2, ALUSrc2=0, SUB, ResultSrc=0 (ALUOut holds the target), branch=1, sel_branch from func3. Next state: FETCH.
  - func3 map: 000→0, 001→1, 100→2, 101→3. Any other func3 is flagged illegal in DECODE.
- **JAL:** ResultSrc=0, PCWrite=1, ALUSrc1=1, ALUSrc2=2, ADD, so ALUOut becomes OldPC+4. Next state: JAL_WB.
- **JALR:** ALUSrc1=2, ALUSrc2=1, ImmSrc=I, ADD. Next state: JALR_PC.
- **JALR_PC:** ResultSrc=0, PCWrite=1, ALUSrc1=1, ALUSrc2=2, ADD. Next state: JAL_WB. Target bit 0 is not cleared.
- **JAL_WB:** ResultSrc=0, RegWrite=1. Next state: FETCH.
- **LUI:** ImmSrc=U, ResultSrc=3, RegWrite=1. Next state: FETCH.

## Timing
- One state per cycle; no stalls and no handshakes. Memory reads are single-cycle.
- Cycles per instruction:
  - 3: branch, lui
  - 4: R-type, I-type, sw, jal
  - 5: lw, jalr
- Reset asserted (rst=0) takes effect immediately, asynchronously, at any state. While rst is low:
  - State is FETCH.
  - PCWrite, IRWrite, MemWrite, RegWrite, branch and illegal_instr are forced to 0.
  - Mux selects show FETCH values.
- First FETCH enables assert in the first cycle after rst rises.
- A mid-instruction reset abandons the instruction; pending MemWrite/RegWrite is dropped.
- Outputs are combinational from state register and IR fields. IR is stable from DECODE until the next FETCH.

## Test plan
- **Reset:** rst=0 mid-MEM_WRITE → MemWrite drops in the same cycle and state=FETCH. Release rst → IRWrite=1 and PCWrite=1 on the next edge.
- **add/sub:** add (func7=0) then sub (func7=0100000) → FETCH, DECODE, EXEC_R, ALU_WB. ALUControl 000 then 001. RegWrite only in cycle 4.
- **lw/sw:** lw → 5 states, AdrSrc=1 in MEM_READ, ResultSrc=1 and RegWrite in MEM_WB. sw → ImmSrc=1, MemWrite=1 only in cycle 4.
- **Branches:** beq/bne/blt/bge (func3 000/001/100/101) → sel_branch 0/1/2/3, branch=1 only in cycle 3, PCWrite=0.
- **Jumps:** jal → PCWrite in cycle 3, RegWrite in cycle 4, ImmSrc=3 in DECODE. jalr → 5 cycles, PCWrite in cycle 4.
- **Illegal:** opcode 1111111, or R-type func3=001 → illegal_instr pulse in DECODE, back to FETCH, and no RegWrite/MemWrite/branch.
